hline_zbuff_ctrl: RTL and testbench
===================================

HLINE_ZBUFF_CTRL -- requirements
Module: hline_zbuff_ctrl

Interface
REQ-001 Parameter MAX_BURST, default 256, max pixels per burst; power of two, range 4..256.
REQ-002 Parameter ZW, default 32, z-value width in bits.
REQ-003 Parameter BPP, default 4, bytes per pixel in both z-buffer and framebuffer.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 nreset  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to draw a line; sampled only in IDLE.
REQ-007 fb_addr  in  32  framebuffer row base address, row y already applied.
REQ-008 zbuff_addr  in  32  z-buffer row base address, row y already applied.
REQ-009 x1, x2  in  16 each  line endpoints, inclusive, either order.
REQ-010 z1  in  ZW  z value at min(x1,x2).
REQ-011 slope  in  ZW  per-pixel z increment, two's complement.
REQ-012 cmp_mode  in  2  depth test: 0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER.
REQ-013 rd_req  out  1  burst read request.
REQ-014 wr_req  out  1  burst write request.
REQ-015 addr  out  32  burst start address.
REQ-016 burst_len  out  $clog2(MAX_BURST)+1  burst length in pixels, 1..MAX_BURST.
REQ-017 axi_done  in  1  one-cycle burst completion pulse.
REQ-018 zin_empty  in  1  z read-FIFO empty.
REQ-019 zin_data  in  ZW  z read-FIFO head (first-word-fall-through).
REQ-020 zin_rd  out  1  pop z read-FIFO.
REQ-021 zout_wr  out  1  push zout_data to z write-FIFO and be_bit to byte-enable FIFO.
REQ-022 zout_data  out  ZW  z value to write back.
REQ-023 be_bit  out  1  1 = pixel passes depth test, written in both buffers.
REQ-024 busy  out  1  high in every state except IDLE.
REQ-025 done  out  1  one-cycle pulse on line completion.

Function
REQ-026 States SHALL be IDLE, RD_Z, INTERP, WR_Z, WR_FB; encoding free.
REQ-027 IDLE with start=1 SHALL latch x_lo=min(x1,x2), remaining=|x1-x2|+1 (17-bit), z_cur=z1, offset=x_lo*BPP (32-bit), cmp_mode, slope; next state RD_Z.
REQ-028 chunk SHALL equal min(remaining, MAX_BURST), held stable from RD_Z entry to WR_FB exit.
REQ-029 RD_Z SHALL assert rd_req, addr=zbuff_addr+offset, burst_len=chunk until axi_done, then go to INTERP with pixel count cleared.
REQ-030 INTERP SHALL, in each cycle with zin_empty=0, assert zin_rd and zout_wr together; no pops or pushes while zin_empty=1.
REQ-031 Per pixel: pass = (LESS: z_cur<zin_data; LEQUAL: z_cur<=zin_data; ALWAYS: 1; NEVER: 0), unsigned compare; be_bit=pass; zout_data = pass ? z_cur : zin_data.
REQ-032 Per pixel z_cur SHALL advance by slope modulo 2^ZW, continuous across chunks.
REQ-033 INTERP SHALL go to WR_Z in the cycle after exactly chunk pixels are pushed.
REQ-034 WR_Z SHALL assert wr_req, addr=zbuff_addr+offset, burst_len=chunk until axi_done, then go to WR_FB.
REQ-035 WR_FB SHALL assert wr_req, addr=fb_addr+offset, burst_len=chunk until axi_done.
REQ-036 On WR_FB axi_done: remaining==chunk -> IDLE with done=1 that cycle; else remaining-=chunk, offset+=chunk*BPP, go to RD_Z.
REQ-037 axi_done SHALL be ignored in IDLE and INTERP; start SHALL be ignored when busy=1.
REQ-038 rd_req, wr_req, zin_rd, zout_wr, done SHALL be 0 outside the states stated above.
REQ-039 x1==x2 SHALL produce one burst set with burst_len=1; |x1-x2|=65535 SHALL produce 256 chunks (MAX_BURST=256) without counter overflow.

Reset
REQ-040 nreset=0 SHALL immediately force IDLE, all outputs 0 (addr, burst_len, zout_data 0), all internal registers 0, aborting any line mid-burst with no done pulse.

Verification
REQ-041 x1=10,x2=13,z1=100,slope=10,LESS, FIFO z={105,105,200,0} -> read addr zbuff+40 len 4; be={1,0,1,0}; zout={100,105,120,0}; one done.
REQ-042 x1=600,x2=0,MAX_BURST=256 -> chunks 256,256,89 at offsets 0,1024,2048; done once after third WR_FB.
REQ-043 zin_empty toggled every other cycle during INTERP -> exactly chunk pops/pushes, no push while empty.
REQ-044 cmp_mode LEQUAL with z_cur==zin_data -> be_bit=1; NEVER -> all be_bit=0, zout_data=zin_data.
REQ-045 nreset low during WR_Z -> outputs 0 same cycle, IDLE, no done; new start after release runs normally.
REQ-046 start pulsed while busy and axi_done pulsed during INTERP -> no effect on state or counters.

Source files
------------

// File: rtl/hline_zbuff_ctrl.sv
// Z-buffered horizontal line controller: reads a z span in bursts, depth-tests and
// interpolates each pixel, then writes the z span and the framebuffer span back.
module hline_zbuff_ctrl #(
    parameter  int MAX_BURST = 256,
    parameter  int ZW        = 32,
    parameter  int BPP       = 4,
    localparam int BLW       = $clog2(MAX_BURST) + 1
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           start,
    input  logic [31:0]    fb_addr,
    input  logic [31:0]    zbuff_addr,
    input  logic [15:0]    x1,
    input  logic [15:0]    x2,
    input  logic [ZW-1:0]  z1,
    input  logic [ZW-1:0]  slope,
    input  logic [1:0]     cmp_mode,
    output logic           rd_req,
    output logic           wr_req,
    output logic [31:0]    addr,
    output logic [BLW-1:0] burst_len,
    input  logic           axi_done,
    input  logic           zin_empty,
    input  logic [ZW-1:0]  zin_data,
    output logic           zin_rd,
    output logic           zout_wr,
    output logic [ZW-1:0]  zout_data,
    output logic           be_bit,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {IDLE, RD_Z, INTERP, WR_Z, WR_FB} state_t;

    state_t         state;
    logic [16:0]    remaining;
    logic [31:0]    offset;
    logic [ZW-1:0]  z_cur;
    logic [ZW-1:0]  slope_r;
    logic [1:0]     mode_r;
    logic [BLW-1:0] pix_cnt;

    logic [BLW-1:0] chunk;
    logic [15:0]    x_lo;
    logic [16:0]    span;
    logic           pass;
    logic           push;
    logic           last_chunk;

    assign x_lo = (x1 < x2) ? x1 : x2;
    assign span = 17'((x1 > x2) ? (x1 - x2) : (x2 - x1)) + 17'd1;

    always_comb begin
        if (remaining > 17'(MAX_BURST)) chunk = BLW'(MAX_BURST);
        else                            chunk = BLW'(remaining);
    end

    // Unsigned depth test against the FIFO head for the current pixel.
    always_comb begin
        case (mode_r)
            2'd0:    pass = (z_cur < zin_data);
            2'd1:    pass = (z_cur <= zin_data);
            2'd2:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign push       = (state == INTERP) && !zin_empty;
    assign last_chunk = (remaining == 17'(chunk));

    assign rd_req    = (state == RD_Z);
    assign wr_req    = (state == WR_Z) || (state == WR_FB);
    assign burst_len = (rd_req || wr_req) ? chunk : '0;
    assign zin_rd    = push;
    assign zout_wr   = push;
    assign zout_data = push ? (pass ? z_cur : zin_data) : '0;
    assign be_bit    = push && pass;
    assign busy      = (state != IDLE);
    assign done      = (state == WR_FB) && axi_done && last_chunk;

    always_comb begin
        case (state)
            RD_Z, WR_Z: addr = zbuff_addr + offset;
            WR_FB:      addr = fb_addr + offset;
            default:    addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            remaining <= '0;
            offset    <= '0;
            z_cur     <= '0;
            slope_r   <= '0;
            mode_r    <= '0;
            pix_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= span;
                        offset    <= 32'(x_lo) * 32'(BPP);
                        z_cur     <= z1;
                        slope_r   <= slope;
                        mode_r    <= cmp_mode;
                        state     <= RD_Z;
                    end
                end
                RD_Z: begin
                    if (axi_done) begin
                        pix_cnt <= '0;
                        state   <= INTERP;
                    end
                end
                INTERP: begin
                    if (push) begin
                        z_cur   <= z_cur + slope_r;
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == chunk - 1'b1) state <= WR_Z;
                    end
                end
                WR_Z: begin
                    if (axi_done) state <= WR_FB;
                end
                WR_FB: begin
                    if (axi_done) begin
                        if (last_chunk) begin
                            state <= IDLE;
                        end else begin
                            remaining <= remaining - 17'(chunk);
                            offset    <= offset + 32'(chunk) * 32'(BPP);
                            state     <= RD_Z;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// Randomized bench for hline_zbuff_ctrl: a bus/FIFO responder feeds the DUT and a
// closed-form line model supplies the expected bursts and per-pixel results.
module tb_hline_zbuff_ctrl;

    localparam int MAX_BURST = 256;
    localparam int ZW        = 32;
    localparam int BPP       = 4;
    localparam int BLW       = $clog2(MAX_BURST) + 1;

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic           start = 1'b0;
    logic [31:0]    fb_addr = 32'h8000_0000;
    logic [31:0]    zbuff_addr = 32'h4000_0000;
    logic [15:0]    x1 = '0, x2 = '0;
    logic [ZW-1:0]  z1 = '0, slope = '0;
    logic [1:0]     cmp_mode = '0;
    logic           rd_req, wr_req;
    logic [31:0]    addr;
    logic [BLW-1:0] burst_len;
    logic           axi_done = 1'b0;
    logic           zin_empty = 1'b1;
    logic [ZW-1:0]  zin_data = '0;
    logic           zin_rd, zout_wr;
    logic [ZW-1:0]  zout_data;
    logic           be_bit, busy, done;

    hline_zbuff_ctrl #(.MAX_BURST(MAX_BURST), .ZW(ZW), .BPP(BPP)) dut (
        .clk(clk), .nreset(nreset), .start(start), .fb_addr(fb_addr),
        .zbuff_addr(zbuff_addr), .x1(x1), .x2(x2), .z1(z1), .slope(slope),
        .cmp_mode(cmp_mode), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .burst_len(burst_len), .axi_done(axi_done), .zin_empty(zin_empty),
        .zin_data(zin_data), .zin_rd(zin_rd), .zout_wr(zout_wr),
        .zout_data(zout_data), .be_bit(be_bit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] a;
        int          len;
    } burst_t;

    int checks = 0;
    int failures = 0;

    logic [ZW-1:0] preset_q[$];
    logic [ZW-1:0] src_q[$];
    logic [ZW-1:0] fifo_q[$];
    logic [ZW-1:0] got_z[$];
    logic          got_be[$];
    burst_t        got_b[$];
    int            src_idx = 0;
    int            done_cnt = 0;
    int            gate_mode = 0;
    bit            noise = 1'b0;
    bit            go = 1'b0;
    bit            pending = 1'b0;
    bit            alt = 1'b0;
    int            countdown = 0;
    bit            prev_busy = 1'b0, prev_done = 1'b0, prev_push = 1'b0, prev_interp = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus responder, FIFO source and output monitor; inputs change on the falling
    // edge and the DUT's combinational outputs are sampled 1 time unit later.
    initial begin
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (axi_done) begin
                axi_done = 1'b0;
                pending  = 1'b0;
            end else if (pending) begin
                countdown--;
                if (countdown == 0) axi_done = 1'b1;
            end else if (noise && prev_interp && !prev_push && $urandom_range(0, 3) == 0) begin
                axi_done = 1'b1;
            end
            if (go) begin
                start = 1'b1;
                go    = 1'b0;
            end else if (noise && prev_busy && !prev_done && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                x1       = 16'($urandom);
                x2       = 16'($urandom);
                z1       = $urandom;
                slope    = $urandom;
                cmp_mode = 2'($urandom);
            end
            alt = ~alt;
            if (fifo_q.size() > 0 && !(gate_mode == 1 && alt) && !(gate_mode == 2 && $urandom_range(0, 2) == 0)) begin
                zin_empty = 1'b0;
                zin_data  = fifo_q[0];
            end else begin
                zin_empty = 1'b1;
                zin_data  = $urandom;
            end
            #1;
            if (zout_wr) begin
                checkOutput("push_while_empty", 64'(zin_empty), 64'd0);
                checkOutput("pop_with_push", 64'(zin_rd), 64'd1);
                got_z.push_back(zout_data);
                got_be.push_back(be_bit);
                if (!zin_empty && fifo_q.size() > 0) void'(fifo_q.pop_front());
            end else if (zin_rd) begin
                checkOutput("pop_without_push", 64'(zout_wr), 64'd1);
            end
            if (done) done_cnt++;
            if (!pending && !axi_done && (rd_req || wr_req)) begin
                got_b.push_back('{kind: (rd_req ? 0 : 1), a: addr, len: int'(burst_len)});
                if (rd_req) begin
                    for (int i = 0; i < int'(burst_len); i++) begin
                        if (src_idx < src_q.size()) begin
                            fifo_q.push_back(src_q[src_idx]);
                            src_idx++;
                        end
                    end
                end
                pending   = 1'b1;
                countdown = $urandom_range(1, 4);
            end
            prev_busy   = busy;
            prev_done   = done;
            prev_push   = zout_wr;
            prev_interp = busy && !rd_req && !wr_req;
        end
    end

    // Runs one line and compares every burst and pixel against the closed-form model;
    // with abort set, reset is pulled during the first z write-back instead.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [ZW-1:0] zz,
                                 input logic [ZW-1:0] sl, input logic [1:0] m, input int gate,
                                 input bit nz, input bit use_preset, input bit abort);
        int n, nch, len, c;
        logic [31:0] off, xlo;
        logic [ZW-1:0] zc, exp_z;
        bit pass;

        @(negedge clk); #3;
        n   = (a > b) ? (int'(a) - int'(b) + 1) : (int'(b) - int'(a) + 1);
        xlo = 32'((a < b) ? a : b);
        src_q.delete(); fifo_q.delete(); got_z.delete(); got_be.delete(); got_b.delete();
        src_idx = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            zc = zz + 32'(i) * sl;
            if (use_preset) src_q.push_back(preset_q[i]);
            else            src_q.push_back(zc + 32'($urandom_range(0, 2)) - 32'd1);
        end
        x1 = a; x2 = b; z1 = zz; slope = sl; cmp_mode = m;
        gate_mode = gate;
        noise = nz;
        go = 1'b1;

        if (abort) begin
            c = 0;
            while (got_b.size() < 2 && c < 5000) begin
                @(negedge clk); c++;
            end
            checkOutput("abort_reached_wr_z", 64'(got_b.size()), 64'd2);
            @(negedge clk); #3;
            nreset = 1'b0;
            #1;
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
            checkOutput("rst_rd_req", 64'(rd_req), 64'd0);
            checkOutput("rst_addr", 64'(addr), 64'd0);
            checkOutput("rst_burst_len", 64'(burst_len), 64'd0);
            checkOutput("rst_zout", {30'd0, zin_rd, zout_wr, zout_data}, 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
            pending = 1'b0;
            axi_done = 1'b0;
            fifo_q.delete();
            repeat (3) @(negedge clk);
            #3;
            nreset = 1'b1;
            repeat (3) @(negedge clk);
            checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
            checkOutput("abort_idle", 64'(busy), 64'd0);
            noise = 1'b0;
            return;
        end

        c = 0;
        while (done_cnt == 0 && c < 20000) begin
            @(negedge clk); c++;
        end
        noise = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("done_count", 64'(done_cnt), 64'd1);
        checkOutput("busy_after", 64'(busy), 64'd0);

        nch = (n + MAX_BURST - 1) / MAX_BURST;
        checkOutput("burst_count", 64'(got_b.size()), 64'(3 * nch));
        for (int k = 0; k < nch && 3 * k + 2 < got_b.size(); k++) begin
            off = xlo * BPP + 32'(k * MAX_BURST * BPP);
            len = (n - k * MAX_BURST > MAX_BURST) ? MAX_BURST : n - k * MAX_BURST;
            checkOutput("rd_kind", 64'(got_b[3*k].kind), 64'd0);
            checkOutput("rd_addr", 64'(got_b[3*k].a), 64'(zbuff_addr + off));
            checkOutput("rd_len", 64'(got_b[3*k].len), 64'(len));
            checkOutput("wz_kind", 64'(got_b[3*k+1].kind), 64'd1);
            checkOutput("wz_addr", 64'(got_b[3*k+1].a), 64'(zbuff_addr + off));
            checkOutput("wz_len", 64'(got_b[3*k+1].len), 64'(len));
            checkOutput("wfb_kind", 64'(got_b[3*k+2].kind), 64'd1);
            checkOutput("wfb_addr", 64'(got_b[3*k+2].a), 64'(fb_addr + off));
            checkOutput("wfb_len", 64'(got_b[3*k+2].len), 64'(len));
        end

        checkOutput("pixel_count", 64'(got_z.size()), 64'(n));
        for (int i = 0; i < n && i < got_z.size(); i++) begin
            zc = zz + 32'(i) * sl;
            case (m)
                2'd0:    pass = (zc < src_q[i]);
                2'd1:    pass = (zc <= src_q[i]);
                2'd2:    pass = 1'b1;
                default: pass = 1'b0;
            endcase
            exp_z = pass ? zc : src_q[i];
            checkOutput("be_bit", 64'(got_be[i]), 64'(pass));
            checkOutput("zout_data", 64'(got_z[i]), 64'(exp_z));
        end
    endtask

    initial begin
        logic [ZW-1:0] exp_zo [4];
        logic          exp_bo [4];
        exp_zo = '{32'd100, 32'd105, 32'd120, 32'd0};
        exp_bo = '{1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_req", {62'd0, rd_req, wr_req}, 64'd0);
        checkOutput("reset_addr", 64'(addr), 64'd0);
        checkOutput("reset_len", 64'(burst_len), 64'd0);
        #2;
        nreset = 1'b1;

        $display("[TB] directed 4-pixel LESS line");
        preset_q = '{32'd105, 32'd105, 32'd200, 32'd0};
        applyStimulus(16'd10, 16'd13, 32'd100, 32'd10, 2'd0, 0, 1'b0, 1'b1, 1'b0);
        if (got_b.size() > 0) checkOutput("dir_rd_addr", 64'(got_b[0].a), 64'(zbuff_addr + 32'd40));
        for (int i = 0; i < 4 && i < got_z.size(); i++) begin
            checkOutput("dir_zout", 64'(got_z[i]), 64'(exp_zo[i]));
            checkOutput("dir_be", 64'(got_be[i]), 64'(exp_bo[i]));
        end

        $display("[TB] 601-pixel reversed line, random FIFO gaps");
        applyStimulus(16'd600, 16'd0, $urandom, $urandom_range(0, 50), 2'd0, 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] single pixel");
        applyStimulus(16'd5, 16'd5, $urandom, $urandom, 2'd1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] exact multiple of burst size");
        applyStimulus(16'd0, 16'd1023, $urandom, $urandom, 2'd1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] alternating empty FIFO");
        applyStimulus(16'd300, 16'd20, $urandom, $urandom, 2'd0, 1, 1'b0, 1'b0, 1'b0);

        $display("[TB] LEQUAL equality");
        preset_q = '{32'd50, 32'd50, 32'd50};
        applyStimulus(16'd7, 16'd9, 32'd50, 32'd0, 2'd1, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < got_be.size(); i++) checkOutput("leq_eq_be", 64'(got_be[i]), 64'd1);

        $display("[TB] NEVER and ALWAYS");
        applyStimulus(16'd40, 16'd70, $urandom, $urandom, 2'd3, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'd1000, 16'd900, $urandom, 32'hFFFF_FFF0, 2'd2, 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] start and axi_done noise while busy");
        applyStimulus(16'd100, 16'd400, $urandom, $urandom_range(0, 9), 2'd0, 2, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during z write-back, then a clean line");
        applyStimulus(16'd0, 16'd40, $urandom, 32'd3, 2'd0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'd3, 16'd60, $urandom, 32'd3, 2'd0, 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] random lines");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(16'($urandom_range(0, 2000)), 16'($urandom_range(0, 2000)), $urandom,
                          $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
